// File: rtl/dmem_pkg.sv
// Shared types and helpers for the wait-state data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_ILL  = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic addr_misaligned(size_e size, logic [1:0] a);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_HALF: bad = a[0];
      SZ_WORD: bad = (a != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: merges right-justified store data into a word and
// extracts/extends the addressed lane for loads.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wr_dat_i,
  input  logic [31:0] old_word_i,
  input  logic        unsigned_i,
  output logic [31:0] st_word_o,
  output logic [31:0] ld_dat_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    st_word_o = old_word_i;
    ld_dat_o  = '0;
    byte_v    = old_word_i[{off_i, 3'b000} +: 8];
    half_v    = old_word_i[{off_i[1], 4'b0000} +: 16];
    case (size_e'(size_i))
      SZ_BYTE: begin
        st_word_o[{off_i, 3'b000} +: 8] = wr_dat_i[7:0];
        ld_dat_o = {{24{~unsigned_i & byte_v[7]}}, byte_v};
      end
      SZ_HALF: begin
        st_word_o[{off_i[1], 4'b0000} +: 16] = wr_dat_i[15:0];
        ld_dat_o = {{16{~unsigned_i & half_v[15]}}, half_v};
      end
      SZ_WORD: begin
        st_word_o = wr_dat_i;
        ld_dat_o  = old_word_i;
      end
      default: begin
        st_word_o = old_word_i;
        ld_dat_o  = '0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_wait_responder.sv
// Data-memory responder with programmable wait states, ready/error handshake,
// sub-word access and range/alignment checking.
module dmem_wait_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH     = 256,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wr_dat,
  input  logic [1:0]  m_size,
  input  logic        m_unsigned,
  output logic [31:0] m_rd_dat,
  output logic        m_ready,
  output logic        m_err,
  output logic        busy
);

  localparam int         AW       = $clog2(DEPTH);
  localparam int         HIW      = 32 - AW - 2;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        accept;

  logic [31:0] addr_q, wdat_q;
  logic [1:0]  size_q;
  logic        uns_q, rd_q, wr_q;

  logic [31:0] mem_q [DEPTH];

  logic        m_ready_q, m_err_q;
  logic [31:0] m_rd_dat_q;

  // Next-state and counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_en | wr_en) begin
          accept  = 1'b1;
          cnt_d   = CNT_INIT;
          state_d = (LATENCY > 1) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With a single-cycle latency RESP is entered on the acceptance edge, before
  // the capture registers hold the request, so the live inputs are used there.
  logic        use_live;
  logic [31:0] c_addr, c_wdat;
  logic [1:0]  c_size;
  logic        c_uns, c_rd, c_wr;

  assign use_live = (state_q == IDLE);
  assign c_addr   = use_live ? m_addr     : addr_q;
  assign c_wdat   = use_live ? m_wr_dat   : wdat_q;
  assign c_size   = use_live ? m_size     : size_q;
  assign c_uns    = use_live ? m_unsigned : uns_q;
  assign c_rd     = use_live ? rd_en      : rd_q;
  assign c_wr     = use_live ? wr_en      : wr_q;

  logic [HIW-1:0] off_hi;
  logic [AW-1:0]  idx;
  logic [1:0]     lane;
  logic           in_range, req_err, enter_resp;
  logic [31:0]    old_word, st_word, ld_dat;

  // BASE_ADDR is DEPTH*4 aligned, so the offset's low bits equal the lane.
  assign {off_hi, idx, lane} = c_addr - BASE_ADDR;
  assign in_range   = (off_hi == '0);
  assign req_err    = (c_rd & c_wr) | (c_size == SZ_ILL) |
                      addr_misaligned(size_e'(c_size), lane) | ~in_range;
  assign old_word   = mem_q[idx];
  assign enter_resp = (state_d == RESP) && (state_q != RESP);

  dmem_lane_align u_align (
    .size_i     (c_size),
    .off_i      (lane),
    .wr_dat_i   (c_wdat),
    .old_word_i (old_word),
    .unsigned_i (c_uns),
    .st_word_o  (st_word),
    .ld_dat_o   (ld_dat)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdat_q     <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      m_ready_q  <= 1'b0;
      m_err_q    <= 1'b0;
      m_rd_dat_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      m_ready_q <= enter_resp;
      m_err_q   <= enter_resp & req_err;
      if (accept) begin
        addr_q <= m_addr;
        wdat_q <= m_wr_dat;
        size_q <= m_size;
        uns_q  <= m_unsigned;
        rd_q   <= rd_en;
        wr_q   <= wr_en;
      end
      // Commit point: store write and load data capture on the edge into RESP
      if (enter_resp) begin
        if (req_err) begin
          m_rd_dat_q <= '0;
        end else begin
          if (c_rd) m_rd_dat_q <= ld_dat;
          if (c_wr) mem_q[idx] <= st_word;
        end
      end
    end
  end

  assign m_ready  = m_ready_q;
  assign m_err    = m_err_q;
  assign m_rd_dat = m_rd_dat_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Directed bench for dmem_wait_responder: LATENCY=2 main instance plus a
// LATENCY=1 instance for the held-request throughput case.
module tb_dmem_wait_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        rd_en, wr_en, m_unsigned;
  logic [31:0] m_addr, m_wr_dat, m_rd_dat;
  logic [1:0]  m_size;
  logic        m_ready, m_err, busy;

  logic        rd_b, wr_b, uns_b;
  logic [31:0] addr_b, wdat_b, rdat_b;
  logic [1:0]  size_b;
  logic        ready_b, err_b, busy_b;

  int checks = 0;
  int errors = 0;

  dmem_wait_responder #(.DEPTH(256), .LATENCY(2), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .reset(reset), .rd_en(rd_en), .wr_en(wr_en), .m_addr(m_addr),
    .m_wr_dat(m_wr_dat), .m_size(m_size), .m_unsigned(m_unsigned),
    .m_rd_dat(m_rd_dat), .m_ready(m_ready), .m_err(m_err), .busy(busy)
  );

  dmem_wait_responder #(.DEPTH(256), .LATENCY(1), .BASE_ADDR(32'h0)) dut_b (
    .clk(clk), .reset(reset), .rd_en(rd_b), .wr_en(wr_b), .m_addr(addr_b),
    .m_wr_dat(wdat_b), .m_size(size_b), .m_unsigned(uns_b),
    .m_rd_dat(rdat_b), .m_ready(ready_b), .m_err(err_b), .busy(busy_b)
  );

  // One request on the LATENCY=2 instance; lat = edges from acceptance to m_ready.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [1:0] sz, input logic uns,
                        output int lat, output int bcnt, output logic [31:0] rdat,
                        output logic err);
    @(negedge clk);
    rd_en = rd; wr_en = wr; m_addr = addr; m_wr_dat = wd; m_size = sz; m_unsigned = uns;
    @(posedge clk); #1;
    rd_en = 1'b0; wr_en = 1'b0;
    lat = -1; bcnt = 0; rdat = 32'hxxxx_xxxx; err = 1'bx;
    for (int n = 0; n < 20; n++) begin
      if (busy) bcnt++;
      if (m_ready) begin
        lat = n; rdat = m_rd_dat; err = m_err;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int lat, bc; logic [31:0] rd; logic er;
    reset = 1'b1;
    rd_en = 0; wr_en = 0; m_addr = 0; m_wr_dat = 0; m_size = 2; m_unsigned = 0;
    rd_b = 0; wr_b = 0; addr_b = 0; wdat_b = 0; size_b = 2; uns_b = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    checks++; if (m_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", m_ready); end
    checks++; if (m_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", m_err); end
    checks++; if (m_rd_dat !== 32'h0) begin errors++; $display("FAIL reset_rdat got %h exp 0", m_rd_dat); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    access(1, 0, 32'h40, 0, 2, 0, lat, bc, rd, er);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_mem got %h exp 0", rd); end
  endtask

  task automatic test_word();
    int lat, bc; logic [31:0] rd; logic er;
    access(0, 1, 32'h10, 32'hDEADBEEF, 2, 0, lat, bc, rd, er);
    checks++; if (lat !== 2) begin errors++; $display("FAIL st_word_lat got %0d exp 2", lat); end
    checks++; if (bc !== 3) begin errors++; $display("FAIL st_word_busy got %0d exp 3", bc); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL st_word_err got %b exp 0", er); end
    access(1, 0, 32'h10, 0, 2, 0, lat, bc, rd, er);
    checks++; if (lat !== 2) begin errors++; $display("FAIL ld_word_lat got %0d exp 2", lat); end
    checks++; if (bc !== 3) begin errors++; $display("FAIL ld_word_busy got %0d exp 3", bc); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL ld_word_data got %h exp deadbeef", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL ld_word_err got %b exp 0", er); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (m_rd_dat !== 32'hDEADBEEF) begin errors++; $display("FAIL rdat_hold got %h exp deadbeef", m_rd_dat); end
  endtask

  task automatic test_byte_half();
    int lat, bc; logic [31:0] rd; logic er;
    access(0, 1, 32'h21, 32'h0000_0080, 0, 0, lat, bc, rd, er);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL st_byte_err got %b exp 0", er); end
    access(1, 0, 32'h21, 0, 0, 0, lat, bc, rd, er);
    checks++; if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL ld_byte_s got %h exp ffffff80", rd); end
    access(1, 0, 32'h21, 0, 0, 1, lat, bc, rd, er);
    checks++; if (rd !== 32'h00000080) begin errors++; $display("FAIL ld_byte_u got %h exp 00000080", rd); end
    access(1, 0, 32'h20, 0, 2, 0, lat, bc, rd, er);
    checks++; if (rd !== 32'h00008000) begin errors++; $display("FAIL ld_word_20 got %h exp 00008000", rd); end
    access(0, 1, 32'h22, 32'h0000_9ABC, 1, 0, lat, bc, rd, er);
    access(1, 0, 32'h20, 0, 2, 0, lat, bc, rd, er);
    checks++; if (rd !== 32'h9ABC8000) begin errors++; $display("FAIL st_half_hi got %h exp 9abc8000", rd); end
    access(1, 0, 32'h22, 0, 1, 0, lat, bc, rd, er);
    checks++; if (rd !== 32'hFFFF9ABC) begin errors++; $display("FAIL ld_half_s got %h exp ffff9abc", rd); end
    access(1, 0, 32'h12, 0, 1, 1, lat, bc, rd, er);
    checks++; if (rd !== 32'h0000DEAD) begin errors++; $display("FAIL ld_half_u got %h exp 0000dead", rd); end
  endtask

  task automatic test_errors();
    int lat, bc; logic [31:0] rd; logic er;
    access(0, 1, 32'h13, 32'h1234, 1, 0, lat, bc, rd, er);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL misalign_err got %b exp 1", er); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL misalign_lat got %0d exp 2", lat); end
    checks++; if (m_ready !== 1'b0 || m_err !== 1'b0) begin errors++; $display("FAIL err_after_resp got %b%b exp 00", m_ready, m_err); end
    access(1, 0, 32'h10, 0, 2, 0, lat, bc, rd, er);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL misalign_nowrite got %h exp deadbeef", rd); end
    access(1, 0, 32'h400, 0, 2, 0, lat, bc, rd, er);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL range_err got %b exp 1", er); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL range_rdat got %h exp 0", rd); end
    access(1, 1, 32'h10, 32'h0, 2, 0, lat, bc, rd, er);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL rdwr_err got %b exp 1", er); end
    access(1, 0, 32'h10, 0, 3, 0, lat, bc, rd, er);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL size3_err got %b exp 1", er); end
    access(1, 0, 32'h11, 0, 2, 0, lat, bc, rd, er);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL word_mis_err got %b exp 1", er); end
    access(1, 0, 32'h10, 0, 2, 0, lat, bc, rd, er);
    checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin errors++; $display("FAIL after_errs got %h/%b exp deadbeef/0", rd, er); end
  endtask

  task automatic test_back_to_back();
    int pulses, first, last, bad_gap;
    pulses = 0; first = -1; last = -1; bad_gap = 0;
    @(negedge clk);
    rd_b = 1'b1; wr_b = 1'b0; addr_b = 32'h0; size_b = 2; uns_b = 0;
    for (int e = 0; e < 10; e++) begin
      @(posedge clk); #1;
      if (ready_b) begin
        if (last >= 0 && (e - last) != 2) bad_gap++;
        if (first < 0) first = e;
        pulses++;
        last = e;
      end
    end
    rd_b = 1'b0;
    checks++; if (pulses !== 5) begin errors++; $display("FAIL b2b_pulses got %0d exp 5", pulses); end
    checks++; if (first !== 0) begin errors++; $display("FAIL b2b_first got %0d exp 0", first); end
    checks++; if (bad_gap !== 0) begin errors++; $display("FAIL b2b_gap got %0d bad gaps exp 0", bad_gap); end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset_abort();
    int lat, bc, seen; logic [31:0] rd; logic er;
    seen = 0;
    @(negedge clk);
    wr_en = 1'b1; rd_en = 1'b0; m_addr = 32'h0; m_wr_dat = 32'hA5A5A5A5; m_size = 2;
    @(posedge clk); #1;
    wr_en = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy got %b exp 1", busy); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    if (m_ready) seen++;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle got %b exp 0", busy); end
    for (int n = 0; n < 5; n++) begin
      @(posedge clk); #1;
      if (m_ready) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_ready got %0d pulses exp 0", seen); end
    access(1, 0, 32'h0, 0, 2, 0, lat, bc, rd, er);
    checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL abort_mem got %h/%b exp 0/0", rd, er); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_half();
    test_errors();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
